// File: rtl/data_mem_responder.sv
// Multicycle data-memory responder: byte-addressable doubleword RAM behind a req/ready/ack
// handshake, with programmable wait states and two-beat handling of doubleword-crossing accesses.
module data_mem_responder #(
    parameter int    DEPTH     = 512,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write,
    input  logic [63:0] addr,
    input  logic [1:0]  size,
    input  logic [63:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic        err,
    output logic [63:0] rdata
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [60:0] DEPTH_DW  = 61'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT0,
        S_BEAT1,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [63:0] mem [DEPTH];

    logic          write_q;
    logic [63:0]   addr_q;
    logic [1:0]    size_q;
    logic [63:0]   wdata_q;
    logic [3:0]    wait_cnt;
    logic [63:0]   stage_lo;

    logic [2:0]    off;
    logic [60:0]   dw0, dw1;
    logic [3:0]    nbytes;
    logic          crossing;
    logic          range_err;
    logic [7:0]    size_bmask;
    logic [63:0]   size_dmask;
    logic [15:0]   wide_bmask;
    logic [127:0]  wide_wdata;
    logic [AW-1:0] idx0, idx1, beat_idx;
    logic [63:0]   rd_word;
    logic [127:0]  ld_src;
    logic [63:0]   ld_data;
    logic          wr_en;
    logic [7:0]    wr_bmask;
    logic [63:0]   wr_data;

    assign off       = addr_q[2:0];
    assign dw0       = addr_q[63:3];
    assign dw1       = dw0 + 61'd1;
    assign nbytes    = 4'd1 << size_q;
    assign crossing  = ({1'b0, off} + nbytes) > 4'd8;
    // The second doubleword of a crossing access must also exist; there is no wrap to doubleword 0.
    assign range_err = (dw0 >= DEPTH_DW) || (crossing && (dw1 >= DEPTH_DW));

    always_comb begin
        size_bmask = 8'hFF;
        size_dmask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (size_q)
            2'b00: begin size_bmask = 8'h01; size_dmask = 64'h0000_0000_0000_00FF; end
            2'b01: begin size_bmask = 8'h03; size_dmask = 64'h0000_0000_0000_FFFF; end
            2'b10: begin size_bmask = 8'h0F; size_dmask = 64'h0000_0000_FFFF_FFFF; end
            default: ;
        endcase
    end

    // Store lanes are laid out across two consecutive doublewords; the upper half feeds BEAT1.
    assign wide_bmask = {8'd0, size_bmask} << off;
    assign wide_wdata = {64'd0, wdata_q & size_dmask} << {off, 3'b000};

    assign idx0     = dw0[AW-1:0];
    assign idx1     = idx0 + AW'(1);
    assign beat_idx = (state == S_BEAT1) ? idx1 : idx0;
    assign rd_word  = mem[beat_idx];

    assign ld_src  = (state == S_BEAT1) ? {rd_word, stage_lo} : {64'd0, rd_word};
    assign ld_data = 64'(ld_src >> {off, 3'b000}) & size_dmask;

    assign wr_en    = write_q && (((state == S_BEAT0) && !range_err) || (state == S_BEAT1));
    assign wr_bmask = (state == S_BEAT1) ? wide_bmask[15:8]   : wide_bmask[7:0];
    assign wr_data  = (state == S_BEAT1) ? wide_wdata[127:64] : wide_wdata[63:0];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_bmask[b]) mem[beat_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req) state_next = (LATENCY > 0) ? S_WAIT : S_BEAT0;
            S_WAIT:  if (wait_cnt == 4'd0) state_next = S_BEAT0;
            S_BEAT0: state_next = (crossing && !range_err) ? S_BEAT1 : S_RESP;
            S_BEAT1: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= 64'd0;
            stage_lo <= 64'd0;
            write_q  <= 1'b0;
            addr_q   <= 64'd0;
            size_q   <= 2'd0;
            wdata_q  <= 64'd0;
        end else begin
            state <= state_next;
            ack   <= (state_next == S_RESP);
            err   <= (state == S_BEAT0) && range_err;
            if ((state == S_IDLE) && req) begin
                write_q  <= write;
                addr_q   <= addr;
                size_q   <= size;
                wdata_q  <= wdata;
                wait_cnt <= WAIT_LOAD;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == S_BEAT0) stage_lo <= rd_word;
            // Stores and rejected accesses return zero so rdata never shows stale load data with ack.
            if (state_next == S_RESP) begin
                rdata <= (write_q || ((state == S_BEAT0) && range_err)) ? 64'd0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with LATENCY=2 and one with LATENCY=0,
// sharing the request bus; sel chooses which instance receives req and is observed.
module tb_data_mem_responder;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        write = 1'b0;
    logic        sel   = 1'b0;
    logic [63:0] addr  = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic [1:0]  size  = 2'd0;

    logic        req_a, req_b;
    logic        ready_a, ack_a, err_a;
    logic        ready_b, ack_b, err_b;
    logic [63:0] rdata_a, rdata_b;
    logic        obs_ready, obs_ack, obs_err;
    logic [63:0] obs_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    assign req_a     = req & ~sel;
    assign req_b     = req & sel;
    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_ack   = sel ? ack_b   : ack_a;
    assign obs_err   = sel ? err_b   : err_a;
    assign obs_rdata = sel ? rdata_b : rdata_a;

    data_mem_responder #(.DEPTH(512), .LATENCY(2), .INIT_FILE("")) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .write(write), .addr(addr), .size(size),
        .wdata(wdata), .ready(ready_a), .ack(ack_a), .err(err_a), .rdata(rdata_a)
    );

    data_mem_responder #(.DEPTH(512), .LATENCY(0), .INIT_FILE("")) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .write(write), .addr(addr), .size(size),
        .wdata(wdata), .ready(ready_b), .ack(ack_b), .err(err_b), .rdata(rdata_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // n counts clock edges from the accept edge up to the edge that captures ack.
    task automatic wait_ack(input bit drop, output int n, output logic e, output logic [63:0] rd);
        n  = 0;
        e  = 1'b0;
        rd = 64'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (drop && (i == 0)) req = 1'b0;
            n++;
            if (obs_ack) begin
                e  = obs_err;
                rd = obs_rdata;
                break;
            end
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic w, input logic [63:0] a,
                                  input logic [1:0] s, input logic [63:0] d, input int exp_lat,
                                  input logic exp_err, input logic [63:0] exp_rd, input bit chk_rd);
        int          lat;
        logic        e;
        logic [63:0] rd;
        @(negedge clk);
        check({tag, "/ready"}, {63'd0, obs_ready}, 64'd1);
        req   = 1'b1;
        write = w;
        addr  = a;
        size  = s;
        wdata = d;
        @(posedge clk);
        wait_ack(1'b1, lat, e, rd);
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/err"}, {63'd0, e}, {63'd0, exp_err});
        if (chk_rd) check({tag, "/rdata"}, rd, exp_rd);
    endtask

    task automatic check_output(input string tag, input logic [63:0] exp_rd);
        @(negedge clk);
        check({tag, "/ack_pulse"}, {63'd0, obs_ack}, 64'd0);
        check({tag, "/err_low"}, {63'd0, obs_err}, 64'd0);
        check({tag, "/rdata_hold"}, obs_rdata, exp_rd);
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [63:0] rd;

        #12;
        check("reset/ready", {63'd0, ready_a}, 64'd1);
        check("reset/ack", {63'd0, ack_a}, 64'd0);
        check("reset/err", {63'd0, err_a}, 64'd0);
        check("reset/rdata", rdata_a, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        apply_stimulus("t1_st_d", 1'b1, 64'h10, 2'b11, 64'h1122334455667788, 4, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t1_ld_d", 1'b0, 64'h10, 2'b11, 64'd0, 4, 1'b0, 64'h1122334455667788, 1'b1);
        check_output("t1_ld_d", 64'h1122334455667788);

        apply_stimulus("t2_st_b", 1'b1, 64'h15, 2'b00, 64'hFFFF_FFFF_FFFF_FFAB, 4, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t2_ld_d", 1'b0, 64'h10, 2'b11, 64'd0, 4, 1'b0, 64'h1122AB4455667788, 1'b1);

        apply_stimulus("t3_clr18", 1'b1, 64'h18, 2'b11, 64'd0, 4, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t3_clr20", 1'b1, 64'h20, 2'b11, 64'd0, 4, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t3_st_w", 1'b1, 64'h1E, 2'b10, 64'h1234_5678_DEAD_BEEF, 5, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t3_ld_w", 1'b0, 64'h1E, 2'b10, 64'd0, 5, 1'b0, 64'h00000000DEADBEEF, 1'b1);
        check_output("t3_ld_w", 64'h00000000DEADBEEF);
        apply_stimulus("t3_ld18", 1'b0, 64'h18, 2'b11, 64'd0, 4, 1'b0, 64'hBEEF000000000000, 1'b1);
        apply_stimulus("t3_ld20", 1'b0, 64'h20, 2'b11, 64'd0, 4, 1'b0, 64'h000000000000DEAD, 1'b1);

        apply_stimulus("t4_st0", 1'b1, 64'h0, 2'b11, 64'h0123456789ABCDEF, 4, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t4_stff8", 1'b1, 64'hFF8, 2'b11, 64'hCAFEF00D12345678, 4, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t4_ld_h_fff", 1'b0, 64'hFFF, 2'b01, 64'd0, 4, 1'b1, 64'd0, 1'b1);
        check_output("t4_ld_h_fff", 64'd0);
        apply_stimulus("t4_st_h_fff", 1'b1, 64'hFFF, 2'b01, 64'h9999, 4, 1'b1, 64'd0, 1'b1);
        apply_stimulus("t4_st_1000", 1'b1, 64'h1000, 2'b11, 64'h5555555555555555, 4, 1'b1, 64'd0, 1'b1);
        apply_stimulus("t4_rb_ff8", 1'b0, 64'hFF8, 2'b11, 64'd0, 4, 1'b0, 64'hCAFEF00D12345678, 1'b1);
        apply_stimulus("t4_rb_0", 1'b0, 64'h0, 2'b11, 64'd0, 4, 1'b0, 64'h0123456789ABCDEF, 1'b1);

        // Request held high across a busy access, with the address changing right after accept.
        @(negedge clk);
        req   = 1'b1;
        write = 1'b0;
        addr  = 64'h10;
        size  = 2'b11;
        @(posedge clk);
        #1 addr = 64'h18;
        wait_ack(1'b0, lat, e, rd);
        check("t5_first/latency", 64'(lat), 64'd4);
        check("t5_first/rdata", rd, 64'h1122AB4455667788);
        check("t5_ack_cycle/ready", {63'd0, obs_ready}, 64'd0);
        @(negedge clk);
        check("t5_after_ack/ready", {63'd0, obs_ready}, 64'd1);
        check("t5_after_ack/ack", {63'd0, obs_ack}, 64'd0);
        @(posedge clk);
        wait_ack(1'b1, lat, e, rd);
        check("t5_second/latency", 64'(lat), 64'd4);
        check("t5_second/rdata", rd, 64'hBEEF000000000000);

        // Reset asserted while a store is still waiting must cancel it without touching RAM.
        apply_stimulus("t6_pre", 1'b1, 64'h40, 2'b11, 64'h7777777777777777, 4, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        req   = 1'b1;
        write = 1'b1;
        addr  = 64'h40;
        size  = 2'b11;
        wdata = 64'h1234123412341234;
        @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        check("t6_wait/ready", {63'd0, obs_ready}, 64'd0);
        reset = 1'b0;
        #1;
        check("t6_rst/ready", {63'd0, obs_ready}, 64'd1);
        check("t6_rst/ack", {63'd0, obs_ack}, 64'd0);
        check("t6_rst/rdata", obs_rdata, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus("t6_rb", 1'b0, 64'h40, 2'b11, 64'd0, 4, 1'b0, 64'h7777777777777777, 1'b1);

        @(negedge clk);
        sel = 1'b1;
        apply_stimulus("t6b_st38", 1'b1, 64'h38, 2'b11, 64'd0, 2, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t6b_st40", 1'b1, 64'h40, 2'b11, 64'hA5A5A5A5A5A5A5A5, 2, 1'b0, 64'd0, 1'b0);
        apply_stimulus("t6b_ld40", 1'b0, 64'h40, 2'b11, 64'd0, 2, 1'b0, 64'hA5A5A5A5A5A5A5A5, 1'b1);
        apply_stimulus("t6b_ld_h3f", 1'b0, 64'h3F, 2'b01, 64'd0, 3, 1'b0, 64'h000000000000A500, 1'b1);
        check_output("t6b_ld_h3f", 64'h000000000000A500);
        apply_stimulus("t6b_ld_fff", 1'b0, 64'hFFF, 2'b01, 64'd0, 2, 1'b1, 64'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
